// File: rtl/dsc_mul_seq.sv
// Purpose: sequences one operand triple at a time through the dsc_mul core (clear, run, settle) and returns the result.
// Latency: N+3 edges from accept to out_valid for a nonzero triple (N = RUN cycles incl. ov); 1 edge for a zero-operand bypass.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, so one idle cycle always separates transactions.
//
// Ports:
//   clk, rst           - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  - operand stream; in_a/in_b/in_c sampled on the transfer edge
//   out_valid/out_ready- result stream; out_z, out_cycles, out_mismatch, out_timeout held while valid
//   core_rst, core_en  - active-high reset and enable driven to the multiplier core
//   core_a/b/c         - registered operands to the core, updated only on accept
//   core_z, core_ov    - core count and completion flag
//   busy               - high whenever the sequencer is not IDLE
module dsc_mul_seq #(
   parameter int NUM_BITS = 6,
   parameter int CYC_W    = 32,
   parameter int TIMEOUT  = 300000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM_BITS-1:0]   in_a,
   input  logic [NUM_BITS-1:0]   in_b,
   input  logic [NUM_BITS-1:0]   in_c,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [3*NUM_BITS-1:0] out_z,
   output logic [CYC_W-1:0]      out_cycles,
   output logic                  out_mismatch,
   output logic                  out_timeout,
   output logic                  core_rst,
   output logic                  core_en,
   output logic [NUM_BITS-1:0]   core_a,
   output logic [NUM_BITS-1:0]   core_b,
   output logic [NUM_BITS-1:0]   core_c,
   input  logic [3*NUM_BITS-1:0] core_z,
   input  logic                  core_ov,
   output logic                  busy
);

   localparam int ZW = 3 * NUM_BITS;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_RUN    = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   // Abort threshold expressed at counter width.
   localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

   logic [2:0]          state;
   logic [NUM_BITS-1:0] op_a;
   logic [NUM_BITS-1:0] op_b;
   logic [NUM_BITS-1:0] op_c;
   logic [ZW-1:0]       expected;
   logic [CYC_W-1:0]    cyc_cnt;
   logic [ZW-1:0]       z_q;
   logic                mismatch_q;
   logic                timeout_q;

   logic [ZW-1:0]       exact_prod;
   logic                any_zero;
   logic [CYC_W-1:0]    cyc_inc;
   logic                hit_timeout;

   // Full-width product: widen each operand before multiplying so nothing truncates.
   assign exact_prod = ZW'(in_a) * ZW'(in_b) * ZW'(in_c);
   assign any_zero   = (in_a == '0) || (in_b == '0) || (in_c == '0);

   // Saturating increment; the count that includes the current RUN cycle.
   assign cyc_inc     = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + CYC_W'(1);
   assign hit_timeout = (cyc_inc >= TIMEOUT_C);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         op_a       <= '0;
         op_b       <= '0;
         op_c       <= '0;
         expected   <= '0;
         cyc_cnt    <= '0;
         z_q        <= '0;
         mismatch_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_a       <= in_a;
                  op_b       <= in_b;
                  op_c       <= in_c;
                  expected   <= exact_prod;
                  cyc_cnt    <= '0;
                  z_q        <= '0;
                  mismatch_q <= 1'b0;
                  timeout_q  <= 1'b0;
                  // A zero operand makes the product trivially 0: skip the core.
                  state      <= any_zero ? S_DONE : S_CLEAR;
               end
            end
            S_CLEAR: begin
               state <= S_RUN;
            end
            S_RUN: begin
               cyc_cnt <= cyc_inc;
               // ov takes priority over a simultaneous timeout.
               if (core_ov) begin
                  state <= S_SETTLE;
               end else if (hit_timeout) begin
                  state      <= S_DONE;
                  z_q        <= core_z;
                  timeout_q  <= 1'b1;
                  mismatch_q <= 1'b1;
               end
            end
            S_SETTLE: begin
               // One extra enabled cycle lets the core's final count land before capture.
               z_q        <= core_z;
               mismatch_q <= (core_z != expected);
               state      <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Control outputs decode straight from state, so an async reset
   // drops the core into reset and withdraws out_valid without waiting for an edge.
   assign in_ready     = (state == S_IDLE);
   assign out_valid    = (state == S_DONE);
   assign core_en      = (state == S_RUN) || (state == S_SETTLE);
   assign core_rst     = !core_en;
   assign busy         = (state != S_IDLE);

   assign core_a       = op_a;
   assign core_b       = op_b;
   assign core_c       = op_c;

   assign out_z        = z_q;
   assign out_cycles   = cyc_cnt;
   assign out_mismatch = mismatch_q;
   assign out_timeout  = timeout_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Purpose: directed self-checking bench for dsc_mul_seq with a behavioural core model.
// Latency: measures accept-to-out_valid edge counts against hand-computed values.
// Backpressure: exercises held results with out_ready low and in_valid pending.
module tb_dsc_mul_seq;

   localparam int W  = 6;
   localparam int ZW = 3 * W;
   localparam int CW = 32;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [W-1:0]  in_c;
   logic          out_valid;
   logic          out_ready;
   logic [ZW-1:0] out_z;
   logic [CW-1:0] out_cycles;
   logic          out_mismatch;
   logic          out_timeout;
   logic          core_rst;
   logic          core_en;
   logic [W-1:0]  core_a;
   logic [W-1:0]  core_b;
   logic [W-1:0]  core_c;
   logic [ZW-1:0] core_z;
   logic          core_ov;
   logic          busy;

   int n_vec = 0;
   int n_err = 0;

   // Core model: mode 0 exact, mode 1 off by one, mode 2 never finishes (z = enable count).
   int            m_mode = 0;
   int            m_cnt  = 0;
   logic [ZW-1:0] m_prod;
   logic          en_seen = 1'b0;

   dsc_mul_seq #(.NUM_BITS(W), .CYC_W(CW), .TIMEOUT(10)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_cycles(out_cycles),
      .out_mismatch(out_mismatch), .out_timeout(out_timeout),
      .core_rst(core_rst), .core_en(core_en),
      .core_a(core_a), .core_b(core_b), .core_c(core_c),
      .core_z(core_z), .core_ov(core_ov),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (core_rst) m_cnt <= 0;
      else if (core_en) m_cnt <= m_cnt + 1;
   end

   always @(negedge clk) begin
      if (core_en) en_seen = 1'b1;
   end

   always_comb begin
      m_prod  = ZW'(core_a) * ZW'(core_b) * ZW'(core_c);
      core_z  = '0;
      core_ov = 1'b0;
      case (m_mode)
         0: begin
            core_ov = core_en && (m_cnt == 4);
            core_z  = (m_cnt >= 4) ? m_prod : '0;
         end
         1: begin
            core_ov = core_en && (m_cnt == 4);
            core_z  = (m_cnt >= 4) ? m_prod - ZW'(1) : '0;
         end
         default: begin
            core_ov = 1'b0;
            core_z  = ZW'(m_cnt);
         end
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges from the accept edge (counted as 1) until out_valid, bounded.
   task automatic wait_out(input int start, output int lat);
      lat = start;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       output int lat);
      in_a = a; in_b = b; in_c = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(1, lat);
   endtask

   task automatic take();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_c = '0;
      tick(); tick();

      // Reset state
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_z", 64'(out_z), 64'd0);
      chk("rst_out_cycles", 64'(out_cycles), 64'd0);
      chk("rst_flags", 64'({out_mismatch, out_timeout}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_core_ctl", 64'({core_rst, core_en}), 64'b10);
      chk("rst_core_ops", 64'({core_a, core_b, core_c}), 64'd0);
      rst = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Nominal nonzero transaction
      m_mode = 0;
      send(6'd3, 6'd5, 6'd7, lat);
      chk("nom_latency", 64'(lat), 64'd8);
      chk("nom_out_z", 64'(out_z), 64'd105);
      chk("nom_cycles", 64'(out_cycles), 64'd5);
      chk("nom_flags", 64'({out_mismatch, out_timeout}), 64'd0);
      chk("nom_core_ops", 64'({core_a, core_b, core_c}), 64'({6'd3, 6'd5, 6'd7}));
      take();
      chk("nom_idle", 64'({out_valid, busy, in_ready}), 64'b001);

      // Zero-operand bypass
      en_seen = 1'b0;
      send(6'd0, 6'd63, 6'd63, lat);
      chk("byp_latency", 64'(lat), 64'd1);
      chk("byp_out_z", 64'(out_z), 64'd0);
      chk("byp_cycles", 64'(out_cycles), 64'd0);
      chk("byp_mismatch", 64'(out_mismatch), 64'd0);
      tick();
      chk("byp_core_en_never", 64'(en_seen), 64'd0);
      take();

      // Wrong core result
      m_mode = 1;
      send(6'd3, 6'd5, 6'd7, lat);
      chk("mis_latency", 64'(lat), 64'd8);
      chk("mis_out_z", 64'(out_z), 64'd104);
      chk("mis_flags", 64'({out_mismatch, out_timeout}), 64'b10);
      take();

      // Timeout: no ov, TIMEOUT = 10 RUN cycles; z is the enable count at the abort edge
      m_mode = 2;
      send(6'd3, 6'd5, 6'd7, lat);
      chk("to_latency", 64'(lat), 64'd12);
      chk("to_flags", 64'({out_mismatch, out_timeout}), 64'b11);
      chk("to_cycles", 64'(out_cycles), 64'd10);
      chk("to_out_z", 64'(out_z), 64'd9);
      chk("to_core_rst", 64'({core_rst, core_en}), 64'b10);
      take();

      // Held result under backpressure with a new triple pending
      m_mode = 0;
      send(6'd3, 6'd5, 6'd7, lat);
      in_a = 6'd1; in_b = 6'd2; in_c = 6'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_stable", 64'({in_ready, out_valid, out_z, out_cycles[7:0], core_a}),
             64'({1'b0, 1'b1, 18'd105, 8'd5, 6'd3}));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hold_handshake_idle", 64'({in_ready, out_valid, core_a}), 64'({1'b1, 1'b0, 6'd3}));
      tick();
      in_valid = 1'b0;
      chk("hold_next_accept", 64'({busy, core_a, core_b, core_c}), 64'({1'b1, 6'd1, 6'd2, 6'd3}));
      wait_out(1, lat);
      chk("hold_next_latency", 64'(lat), 64'd8);
      chk("hold_next_out_z", 64'(out_z), 64'd6);
      chk("hold_next_mismatch", 64'(out_mismatch), 64'd0);
      take();

      // Reset during RUN cycle 3
      in_a = 6'd3; in_b = 6'd5; in_c = 6'd7;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("abort_in_run", 64'({core_en, core_rst}), 64'b10);
      rst = 1'b0;
      #1;
      chk("abort_immediate", 64'({core_rst, core_en, out_valid, busy}), 64'b1000);
      tick();
      rst = 1'b1;
      tick();
      chk("abort_no_output", 64'({out_valid, in_ready}), 64'b01);
      send(6'd63, 6'd63, 6'd63, lat);
      chk("post_rst_latency", 64'(lat), 64'd8);
      chk("post_rst_out_z", 64'(out_z), 64'd250047);
      chk("post_rst_cycles", 64'(out_cycles), 64'd5);
      chk("post_rst_flags", 64'({out_mismatch, out_timeout}), 64'd0);
      take();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
